// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WA_DEF = 8;
   localparam int WB_DEF = 4;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_width(input int wb);
      return (wb < 2) ? 1 : $clog2(wb);
   endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: adds the multiplicand shifted by cnt when the
// selected multiplier bit is set. Purely combinational.
module mul_step #(
   parameter int WA = 8,
   parameter int WB = 4,
   parameter int CW = 2
) (
   input  logic [WA+WB-1:0] acc,
   input  logic [WA-1:0]    a_reg,
   input  logic             b_bit,
   input  logic [CW-1:0]    cnt,
   output logic [WA+WB-1:0] acc_next
);

   logic [WA+WB-1:0] partial;

   always_comb begin
      partial  = {{WB{1'b0}}, a_reg} << cnt;
      acc_next = b_bit ? (acc + partial) : acc;
   end

endmodule

// File: rtl/mul_seq.sv
// Sequential multiplier p = a*b (+ r when MUL_SEQ_ADDEND_EN is defined),
// one multiplier bit per clock, one operation in flight.
module mul_seq
   import mul_pkg::*;
#(
   parameter int WA = WA_DEF,
   parameter int WB = WB_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WA-1:0]    a,
   input  logic [WB-1:0]    b,
   input  logic [WB-1:0]    r,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WA+WB-1:0] p
);

   localparam int          CW   = cnt_width(WB);
   localparam int          WP   = WA + WB;
   localparam logic [CW-1:0] LAST = CW'(WB - 1);

`ifdef MUL_SEQ_ADDEND_EN
   localparam logic ADDEND_EN = 1'b1;
`else
   localparam logic ADDEND_EN = 1'b0;
`endif

   state_t          state;
   state_t          state_next;
   logic [WA-1:0]   a_reg;
   logic [WB-1:0]   b_reg;
   logic [WP-1:0]   acc;
   logic [WP-1:0]   acc_next;
   logic [WP-1:0]   acc_init;
   logic [CW-1:0]   cnt;
   logic            accept;

   // Handshake: a request is taken on any rising edge where start and ready
   // are both high; ready is high in IDLE and in the single DONE cycle, so a
   // start held through DONE is taken back-to-back. start while busy is dropped.
   assign ready  = (state == IDLE) || (state == DONE);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign accept = start && ready;

   // With the addend disabled r is masked to zero, keeping the port in place.
   assign acc_init = {{WA{1'b0}}, r & {WB{ADDEND_EN}}};

   mul_step #(
      .WA (WA),
      .WB (WB),
      .CW (CW)
   ) u_step (
      .acc      (acc),
      .a_reg    (a_reg),
      .b_bit    (b_reg[cnt]),
      .cnt      (cnt),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt == LAST) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
         p     <= '0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         acc   <= acc_init;
         cnt   <= '0;
      end else if (state == RUN) begin
         acc <= acc_next;
         cnt <= cnt + 1'b1;
         // The final step lands in p so it is valid throughout DONE and holds after.
         if (cnt == LAST) p <= acc_next;
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq with hand-computed results for
// both the addend-enabled and addend-disabled builds.
module tb_mul_seq;

   localparam int WA = 8;
   localparam int WB = 4;

`ifdef MUL_SEQ_ADDEND_EN
   localparam bit ADD_ON = 1'b1;
`else
   localparam bit ADD_ON = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             start;
   logic [WA-1:0]    a;
   logic [WB-1:0]    b;
   logic [WB-1:0]    r;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WA+WB-1:0] p;

   int n_checks;
   int n_fail;

   mul_seq #(.WA(WA), .WB(WB)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .r     (r),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick(input logic [31:0] on_val, input logic [31:0] off_val);
      return ADD_ON ? on_val : off_val;
   endfunction

   // Called just after the accept edge. Checks WB RUN cycles, then the DONE
   // cycle; clear_at drops start after that many RUN edges (-1 = leave it).
   task automatic wait_result(input string tag, input logic [31:0] exp,
                              input int clear_at, input bit check_hold);
      for (int i = 0; i < WB; i++) begin
         check_eq({tag, "_run_flags"}, {29'd0, busy, done, ready}, 32'b100);
         tick();
         if (i + 1 == clear_at) start = 1'b0;
      end
      check_eq({tag, "_done_flags"}, {29'd0, busy, done, ready}, 32'b011);
      check_eq({tag, "_p"}, {20'd0, p}, exp);
      if (check_hold) begin
         tick();
         check_eq({tag, "_after_flags"}, {29'd0, busy, done, ready}, 32'b001);
         check_eq({tag, "_p_hold"}, {20'd0, p}, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [WA-1:0] ai, input logic [WB-1:0] bi,
                         input logic [WB-1:0] ri, input logic [31:0] exp);
      check_eq({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
      a     = ai;
      b     = bi;
      r     = ri;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_result(tag, exp, -1, 1'b1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      r        = '0;
      tick();
      tick();
      check_eq("reset_flags", {29'd0, busy, done, ready}, 32'b001);
      check_eq("reset_p", {20'd0, p}, 32'd0);
      rst = 1'b0;
      tick();

      // main function and extremes
      run_op("basic",    8'd200, 4'd13, 4'd7,  pick(32'd2607, 32'd2600));
      run_op("extreme",  8'd255, 4'd15, 4'd15, pick(32'd3840, 32'd3825));
      run_op("zeros",    8'd0,   4'd0,  4'd0,  32'd0);
      run_op("b_zero",   8'd99,  4'd0,  4'd5,  pick(32'd5, 32'd0));
      run_op("msb_only", 8'd1,   4'd8,  4'd0,  32'd8);
      run_op("mixed",    8'd128, 4'd9,  4'd3,  pick(32'd1155, 32'd1152));
      run_op("b_one",    8'd255, 4'd1,  4'd0,  32'd255);

      // start pulsed during RUN is ignored
      a = 8'd10; b = 4'd3; r = 4'd1; start = 1'b1;
      tick();
      a = 8'd1; b = 4'd1; r = 4'd0;
      wait_result("ignore", pick(32'd31, 32'd30), 1, 1'b1);
      tick();
      check_eq("ignore_idle_flags", {29'd0, busy, done, ready}, 32'b001);

      // back-to-back: op2 request held from RUN through DONE
      a = 8'd12; b = 4'd5; r = 4'd2; start = 1'b1;
      tick();
      a = 8'd3; b = 4'd4; r = 4'd1;
      wait_result("b2b_op1", pick(32'd62, 32'd60), -1, 1'b0);
      tick();
      start = 1'b0;
      wait_result("b2b_op2", pick(32'd13, 32'd12), -1, 1'b1);

      // reset during the second RUN cycle
      a = 8'd50; b = 4'd6; r = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_flags", {29'd0, busy, done, ready}, 32'b001);
      check_eq("midrst_p", {20'd0, p}, 32'd0);
      for (int i = 0; i < WB + 2; i++) begin
         check_eq("midrst_no_done", {31'd0, done}, 32'd0);
         tick();
      end
      run_op("after_rst", 8'd7, 4'd7, 4'd0, 32'd49);

      // reset and start together: reset wins
      a = 8'd5; b = 4'd5; r = 4'd0; start = 1'b1; rst = 1'b1;
      tick();
      start = 1'b0; rst = 1'b0;
      check_eq("rst_start_flags", {29'd0, busy, done, ready}, 32'b001);
      check_eq("rst_start_p", {20'd0, p}, 32'd0);
      tick();
      check_eq("rst_start_idle", {29'd0, busy, done, ready}, 32'b001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
